sort_engine: RTL and testbench

Parametrised sequential sorting block built on compare-exchange cells. It accepts a frame of `DEPTH` unsigned `WIDTH`-bit words over a valid/ready input and sorts them in place with an odd-even transposition network, one pass per cycle. It then streams the sorted frame out over a valid/ready output. Sort order is ascending or descending, selectable per frame. It is the frame-level successor to the single 3-bit compare-exchange cell.

---
 rtl/sort_engine.sv | 78 +++++++
 tb/tb_sort_engine.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sort_engine.sv
// sort_engine: frame sorter using an odd-even transposition network, one pass per cycle
module sort_engine #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             descend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] rd_idx;
  logic [CW-1:0] pass;
  logic mode;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] srt [DEPTH];
  assign in_ready = state == LOAD;
  assign out_valid = state == DRAIN;
  assign busy = (state == SORT) || (state == DRAIN);
  assign out_data = mem[rd_idx];
  // one transposition pass: even passes pair (0,1),(2,3)..., odd passes pair (1,2),(3,4)...; equal words stay put
  always_comb begin
    srt = mem;
    for (int i = 0; i < DEPTH - 1; i++)
      if ((i % 2) == int'(pass[0]) && (mode ? mem[i] < mem[i+1] : mem[i] > mem[i+1])) begin
        srt[i] = mem[i+1];
        srt[i+1] = mem[i];
      end
  end
  // frame control: load words, run DEPTH passes, then stream the sorted frame out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_idx <= '0;
      rd_idx <= '0;
      pass <= '0;
      mode <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: state <= LOAD;
        LOAD: if (in_valid) begin
          mem[wr_idx] <= in_data;
          if (wr_idx == '0) mode <= descend;
          if (wr_idx == LAST) begin
            wr_idx <= '0;
            pass <= '0;
            state <= SORT;
          end else wr_idx <= wr_idx + 1'b1;
        end
        SORT: begin
          mem <= srt;
          if (pass == LAST) begin
            rd_idx <= '0;
            state <= DRAIN;
          end else pass <= pass + 1'b1;
        end
        DRAIN: if (out_ready) begin
          if (rd_idx == LAST) begin
            rd_idx <= '0;
            state <= LOAD;
          end else rd_idx <= rd_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: table-driven frames with a scoreboard queue, plus reset corner cases
module tb_sort_engine;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [2:0] in_data = 0;
  logic descend = 0;
  logic out_valid;
  logic out_ready = 0;
  logic [2:0] out_data;
  logic busy;
  int checks = 0;
  int errors = 0;
  logic [2:0] sb[$];

  typedef struct {
    bit desc;
    bit flip;
    bit gaps;
    bit bp;
    logic [2:0] d[8];
    logic [2:0] e[8];
  } vec_t;
  vec_t v[5];

  sort_engine #(.WIDTH(3), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .descend(descend), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input vec_t t, input bit push);
    for (int j = 0; j < 8; j++) begin
      if (t.gaps && j > 0) begin
        in_valid = 0;
        in_data = 3'($urandom);
        descend = 1'($urandom);
        step();
        chk("gap_ready", in_ready, 1);
      end
      in_valid = 1;
      in_data = t.d[j];
      descend = (t.flip && j > 0) ? ~t.desc : t.desc;
      if (push) sb.push_back(t.e[j]);
      chk("load_ready", in_ready, 1);
      step();
    end
    in_valid = 0;
    descend = 1'($urandom);
  endtask

  task automatic run_frame(input vec_t t);
    int n, cyc;
    bit held;
    logic [2:0] hv;
    load_frame(t, 1);
    chk("sort_busy", busy, 1);
    chk("sort_in_ready", in_ready, 0);
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("latency_valid", out_valid, c == 8);
      chk("busy", busy, 1);
    end
    n = 0;
    cyc = 0;
    held = 0;
    hv = 0;
    while (n < 8 && cyc < 64) begin
      out_ready = t.bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      chk("drain_in_ready", in_ready, 0);
      if (held) chk("stall_stable", out_data, hv);
      held = out_valid && !out_ready;
      hv = out_data;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else chk("out_data", out_data, sb.pop_front());
        n++;
      end
      step();
      cyc++;
    end
    out_ready = 0;
    if (cyc >= 64) chk("drain_timeout", n, 8);
    chk("ready_after_drain", in_ready, 1);
    chk("valid_after_drain", out_valid, 0);
    chk("busy_after_drain", busy, 0);
  endtask

  initial begin
    vec_t ab, nf;
    v[0].desc = 0; v[0].flip = 0; v[0].gaps = 0; v[0].bp = 0;
    v[0].d = '{5, 7, 0, 3, 6, 1, 4, 2}; v[0].e = '{0, 1, 2, 3, 4, 5, 6, 7};
    v[1].desc = 1; v[1].flip = 1; v[1].gaps = 0; v[1].bp = 0;
    v[1].d = '{3, 3, 7, 0, 7, 1, 1, 5}; v[1].e = '{7, 7, 5, 3, 3, 1, 1, 0};
    v[2].desc = 0; v[2].flip = 0; v[2].gaps = 0; v[2].bp = 1;
    v[2].d = '{6, 2, 6, 0, 5, 5, 1, 3}; v[2].e = '{0, 1, 2, 3, 5, 5, 6, 6};
    v[3].desc = 0; v[3].flip = 1; v[3].gaps = 1; v[3].bp = 0;
    v[3].d = '{7, 6, 5, 4, 3, 2, 1, 0}; v[3].e = '{0, 1, 2, 3, 4, 5, 6, 7};
    v[4].desc = 1; v[4].flip = 0; v[4].gaps = 1; v[4].bp = 1;
    v[4].d = '{0, 1, 2, 3, 4, 5, 6, 7}; v[4].e = '{7, 6, 5, 4, 3, 2, 1, 0};

    for (int c = 0; c < 4; c++) begin
      in_valid = 1'($urandom);
      in_data = 3'($urandom);
      descend = 1'($urandom);
      out_ready = 1'($urandom);
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
    end
    in_valid = 0;
    out_ready = 0;
    rst_n = 1;
    #1;
    chk("idle_in_ready", in_ready, 0);
    step();
    chk("post_rst_in_ready", in_ready, 1);

    for (int k = 0; k < 5; k++) run_frame(v[k]);

    ab.desc = 1; ab.flip = 0; ab.gaps = 0; ab.bp = 0;
    ab.d = '{7, 7, 6, 7, 5, 7, 6, 7}; ab.e = '{7, 7, 7, 7, 7, 6, 6, 5};
    load_frame(ab, 0);
    step();
    step();
    step();
    rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_data", out_data, 0);
    step();
    rst_n = 1;
    step();
    chk("abort_relaunch_ready", in_ready, 1);
    nf.desc = 0; nf.flip = 0; nf.gaps = 0; nf.bp = 1;
    nf.d = '{2, 1, 0, 3, 1, 4, 2, 0}; nf.e = '{0, 0, 1, 1, 2, 2, 3, 4};
    run_frame(nf);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
